// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Data width and FSM state encodings used by top and array.
package dmem_responder_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables.
// The read data is registered and held until the next read.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write: only strobed lanes change
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read, held between reads
    always_ff @(posedge i_clk) begin
        if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Request/response front end for the data-memory array.
// Accepts one request at a time, waits LATENCY cycles, then responds.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LAT_M1 = 3'(LATENCY - 1);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic                r_rd_sel;
    logic                r_we;
    logic                r_ok;
    logic [AW-1:0]       r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic [63:0]         w_off;
    logic                w_in_range;
    logic [AW-1:0]       w_idx;
    logic                w_accept;
    logic                w_from_in;
    logic                w_fire;
    logic                w_a_we;
    logic                w_a_ok;
    logic [AW-1:0]       w_a_idx;
    logic [DATA_W-1:0]   w_a_wdata;
    logic [STRB_W-1:0]   w_a_wstrb;
    logic [DATA_W-1:0]   w_arr_rdata;

    assign w_off      = req_addr - BASE_ADDR;
    assign w_in_range = (req_addr >= BASE_ADDR) &&
                        ((w_off >> 3) < 64'(DEPTH));
    assign w_idx      = w_off[AW+2:3];
    assign w_accept   = req_valid && (r_state == ST_IDLE);

    // With zero latency the access uses the live request, else the latch
    assign w_from_in  = (r_state == ST_IDLE);
    assign w_fire     = sys_rst &&
                        ((w_accept && (LATENCY == 0)) ||
                         ((r_state == ST_ACCESS) && (r_cnt == 3'd0)));
    assign w_a_we     = w_from_in ? req_we     : r_we;
    assign w_a_ok     = w_from_in ? w_in_range : r_ok;
    assign w_a_idx    = w_from_in ? w_idx      : r_idx;
    assign w_a_wdata  = w_from_in ? req_wdata  : r_wdata;
    assign w_a_wstrb  = w_from_in ? req_wstrb  : r_wstrb;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (sys_clk),
        .i_en    (w_fire && w_a_ok),
        .i_we    (w_a_we),
        .i_addr  (w_a_idx),
        .i_wdata (w_a_wdata),
        .i_wstrb (w_a_wstrb),
        .o_rdata (w_arr_rdata)
    );

    // Latch the accepted request for the delayed access
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_ok    <= w_in_range;
            r_idx   <= w_idx;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_sel     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= !w_in_range;
                            r_rd_sel     <= w_in_range && !req_we;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 3'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= !r_ok;
                        r_rd_sel     <= r_ok && !r_we;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rd_sel     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three latencies, directed and random traffic.
// Instance 0 is tracked cycle by cycle against a word-array model.
module tb_dmem_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int          DEP  = 512;
    localparam int          LAT0 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [63:0] req_addr   [3];
    logic [63:0] req_wdata  [3];
    logic [7:0]  req_wstrb  [3];
    logic        resp_ready [3];

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic        err0, err1, err2;
    logic [63:0] rd0, rd1, rd2;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] m_mem [DEP];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .sys_clk(clk), .sys_rst(rst_n),
        .req_valid(req_valid[0]), .req_ready(rdy0), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_wstrb(req_wstrb[0]), .resp_valid(vld0),
        .resp_ready(resp_ready[0]), .resp_rdata(rd0), .resp_err(err0));

    dmem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(0)) u_l0 (
        .sys_clk(clk), .sys_rst(rst_n),
        .req_valid(req_valid[1]), .req_ready(rdy1), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_wstrb(req_wstrb[1]), .resp_valid(vld1),
        .resp_ready(resp_ready[1]), .resp_rdata(rd1), .resp_err(err1));

    dmem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(7)) u_l7 (
        .sys_clk(clk), .sys_rst(rst_n),
        .req_valid(req_valid[2]), .req_ready(rdy2), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_wstrb(req_wstrb[2]), .resp_valid(vld2),
        .resp_ready(resp_ready[2]), .resp_rdata(rd2), .resp_err(err2));

    function automatic logic f_rdy(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic f_vld(input int k);
        case (k)
            0:       return vld0;
            1:       return vld1;
            default: return vld2;
        endcase
    endfunction

    function automatic logic f_err(input int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    function automatic logic [63:0] f_rd(input int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction; starts and ends at posedge+1
    task automatic xact(input int k, input logic we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] st,
                        input int hold, output logic [63:0] rd,
                        output logic er, output int rise);
        int n;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        req_wstrb[k] = st;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_rdy(k) && n < 50);
        if (!f_rdy(k)) chk("accept_timeout", 64'(f_rdy(k)), 64'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        rise = 1;
        forever begin
            @(negedge clk);
            if (f_vld(k) || rise > 20) break;
            rise++;
        end
        if (!f_vld(k)) chk("resp_timeout", 64'(f_vld(k)), 64'd1);
        rd = f_rd(k);
        er = f_err(k);
        @(posedge clk);
        #1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1 resp_ready[k] = 1'b0;
    endtask

    // Cycle-by-cycle model of instance 0
    initial begin : monitor
        logic        busy;
        logic        done;
        int          wait_n;
        logic        p_we;
        logic [63:0] p_addr;
        logic [63:0] p_wd;
        logic [7:0]  p_st;
        logic [63:0] e_rd;
        logic        e_err;
        logic [63:0] off;
        int          idx;
        busy = 1'b0;
        done = 1'b0;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                chk("mon_rst_ready", 64'(rdy0), 64'd1);
                chk("mon_rst_valid", 64'(vld0), 64'd0);
                chk("mon_rst_rdata", rd0, 64'd0);
                chk("mon_rst_err", 64'(err0), 64'd0);
            end else if (!busy) begin
                chk("mon_idle_ready", 64'(rdy0), 64'd1);
                chk("mon_idle_valid", 64'(vld0), 64'd0);
                if (req_valid[0]) begin
                    busy   = 1'b1;
                    done   = 1'b0;
                    wait_n = LAT0;
                    p_we   = req_we[0];
                    p_addr = req_addr[0];
                    p_wd   = req_wdata[0];
                    p_st   = req_wstrb[0];
                end
            end else begin
                chk("mon_busy_ready", 64'(rdy0), 64'd0);
                if (wait_n > 0) begin
                    chk("mon_wait_valid", 64'(vld0), 64'd0);
                    wait_n--;
                end else begin
                    if (!done) begin
                        done = 1'b1;
                        off  = p_addr - BASE;
                        if (p_addr >= BASE && off / 8 < DEP) begin
                            idx   = int'(off / 8);
                            e_err = 1'b0;
                            e_rd  = 64'd0;
                            if (p_we) begin
                                for (int b = 0; b < 8; b++)
                                    if (p_st[b])
                                        m_mem[idx][8*b +: 8] = p_wd[8*b +: 8];
                            end else begin
                                e_rd = m_mem[idx];
                            end
                        end else begin
                            e_err = 1'b1;
                            e_rd  = 64'd0;
                        end
                    end
                    chk("mon_resp_valid", 64'(vld0), 64'd1);
                    chk("mon_resp_rdata", rd0, e_rd);
                    chk("mon_resp_err", 64'(err0), 64'(e_err));
                    if (resp_ready[0]) busy = 1'b0;
                end
            end
        end
    end

    initial begin : main
        logic [63:0] rd;
        logic        er;
        int          rise;
        int          n;
        logic [63:0] a;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_addr[k]   = 64'd0;
            req_wdata[k]  = 64'd0;
            req_wstrb[k]  = 8'd0;
            resp_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_l0", 64'(rdy1), 64'd1);
        chk("rst_valid_l7", 64'(vld2), 64'd0);
        chk("rst_rdata_l7", rd2, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < DEP; i++)
            xact(0, 1'b1, BASE + 64'(8 * i), {$urandom, $urandom},
                 8'hFF, 0, rd, er, rise);

        for (int k = 0; k < 3; k++) begin
            xact(k, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788,
                 8'hFF, 0, rd, er, rise);
            chk("wr_rdata", rd, 64'd0);
            chk("wr_err", 64'(er), 64'd0);
            xact(k, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, rd, er, rise);
            chk("rd_rdata", rd, 64'h1122_3344_5566_7788);
            chk("rd_err", 64'(er), 64'd0);
            case (k)
                0:       chk("rise_lat1", 64'(rise), 64'd2);
                1:       chk("rise_lat0", 64'(rise), 64'd1);
                default: chk("rise_lat7", 64'(rise), 64'd8);
            endcase
        end

        xact(0, 1'b1, 64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA,
             8'h0F, 1, rd, er, rise);
        xact(0, 1'b0, 64'h8000_000D, 64'd0, 8'h00, 0, rd, er, rise);
        chk("strobe_lo", rd, 64'h1122_3344_AAAA_AAAA);

        xact(0, 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF,
             8'h00, 0, rd, er, rise);
        chk("nostrb_err", 64'(er), 64'd0);
        xact(0, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, rd, er, rise);
        chk("nostrb_keep", rd, 64'h1122_3344_AAAA_AAAA);

        xact(0, 1'b0, 64'h8000_1000, 64'd0, 8'hFF, 0, rd, er, rise);
        chk("oor_hi_err", 64'(er), 64'd1);
        chk("oor_hi_rdata", rd, 64'd0);
        xact(0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'hFF, 0, rd, er, rise);
        chk("oor_lo_err", 64'(er), 64'd1);
        chk("oor_lo_rdata", rd, 64'd0);
        xact(0, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF_DEAD_BEEF,
             8'hFF, 0, rd, er, rise);
        chk("oor_wr_err", 64'(er), 64'd1);
        xact(0, 1'b0, 64'h8000_0FF8, 64'd0, 8'h00, 0, rd, er, rise);
        chk("last_word_err", 64'(er), 64'd0);

        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 64'h8000_0008;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy0 && n < 50);
        @(posedge clk);
        #1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 64'h8000_0018;
        req_wdata[0] = 64'h5555_6666_7777_8888;
        req_wstrb[0] = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld0 && n < 50);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_ready", 64'(rdy0), 64'd0);
            chk("hold_valid", 64'(vld0), 64'd1);
            chk("hold_rdata", rd0, 64'h1122_3344_AAAA_AAAA);
        end
        @(posedge clk);
        #1 resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;
        @(negedge clk);
        chk("pend_ready_up", 64'(rdy0), 64'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("pend_accepted", 64'(rdy0), 64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld0 && n < 50);
        @(posedge clk);
        #1 resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;
        xact(0, 1'b0, 64'h8000_0018, 64'd0, 8'h00, 0, rd, er, rise);
        chk("pend_write", rd, 64'h5555_6666_7777_8888);

        xact(0, 1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF,
             8'hFF, 0, rd, er, rise);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 64'h8000_0010;
        req_wdata[0] = 64'hDEAD_DEAD_DEAD_DEAD;
        req_wstrb[0] = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy0 && n < 50);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("access_busy", 64'(rdy0), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(rdy0), 64'd1);
        chk("arst_valid", 64'(vld0), 64'd0);
        chk("arst_rdata", rd0, 64'd0);
        chk("arst_err", 64'(err0), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xact(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, rd, er, rise);
        chk("arst_no_commit", rd, 64'h0123_4567_89AB_CDEF);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + 64'(8 * DEP) + 64'(8 * $urandom_range(0, 100));
                1: a = BASE - 64'(8 * $urandom_range(1, 100));
                2: a = {$urandom, $urandom};
                3, 4, 5: a = BASE + 64'(8 * $urandom_range(0, 7)) +
                             64'($urandom_range(0, 7));
                default: a = BASE + 64'(8 * $urandom_range(0, DEP - 1)) +
                             64'($urandom_range(0, 7));
            endcase
            xact(0, 1'($urandom), a, {$urandom, $urandom},
                 8'($urandom), $urandom_range(0, 3), rd, er, rise);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
